// File: rtl/cpu_controller.sv
// cpu_controller: instruction register, decoder and control sequencer for the
// Simple RISC Machine datapath. It latches a 16-bit instruction and then steps
// through the datapath strobes for MOV and ALU instructions, one phase per cycle.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_WAIT      | idle; waiting=1; load updates the IR; start begins execution
// S_DECODE    | classify the IR; no strobes asserted
// S_WRITE_IMM | write sximm8 into Rn
// S_GET_A     | read Rn into A
// S_GET_B     | read Rm into B
// S_OPERATE   | shift/ALU; load C (except CMP) and status (ALU class only)
// S_WRITE_REG | write C into Rd
//
// The control outputs are registered. Their next values are decoded from the
// next state and the next IR value, so each output is valid for the whole
// cycle its state is active and depends only on that state and the IR.
module cpu_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        load,
  input  logic        start,
  output logic        waiting,
  output logic [2:0]  w_addr,
  output logic [2:0]  r_addr,
  output logic        w_en,
  output logic [1:0]  wb_sel,
  output logic        en_A,
  output logic        en_B,
  output logic        en_C,
  output logic        en_status,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  shift_op,
  output logic [1:0]  ALU_op,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_OPERATE   = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  localparam logic [1:0] SUB_MOV_IMM = 2'b10;
  localparam logic [1:0] SUB_MOV_REG = 2'b00;
  localparam logic [1:0] SUB_CMP     = 2'b01;
  localparam logic [1:0] SUB_MVN     = 2'b11;

  localparam logic [1:0] WB_C      = 2'b00;
  localparam logic [1:0] WB_SXIMM8 = 2'b10;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic        waiting_q, waiting_d;
  logic [2:0]  w_addr_q, w_addr_d;
  logic [2:0]  r_addr_q, r_addr_d;
  logic        w_en_q, w_en_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic        en_a_q, en_a_d;
  logic        en_b_q, en_b_d;
  logic        en_c_q, en_c_d;
  logic        en_status_q, en_status_d;
  logic        sel_a_q, sel_a_d;
  logic [1:0]  shift_op_q, shift_op_d;
  logic [1:0]  alu_op_q, alu_op_d;

  // Fields of the current IR, used to pick the path out of DECODE.
  logic [2:0] cur_op;
  logic [1:0] cur_sub;
  logic       cur_mov_imm, cur_mov_reg, cur_alu, cur_needs_a;

  // Fields of the next IR, used to decode the registered outputs.
  logic [2:0] nxt_op;
  logic [1:0] nxt_sub;
  logic [2:0] nxt_rn, nxt_rd, nxt_rm;
  logic [1:0] nxt_sh;
  logic       nxt_mov_reg, nxt_cmp;

  // Instruction classification for sequencing.
  always_comb begin
    cur_op      = ir_q[15:13];
    cur_sub     = ir_q[12:11];
    cur_mov_imm = (cur_op == OP_MOV) && (cur_sub == SUB_MOV_IMM);
    cur_mov_reg = (cur_op == OP_MOV) && (cur_sub == SUB_MOV_REG);
    cur_alu     = (cur_op == OP_ALU);
    // MVN is single-operand and skips the A read, like MOV reg.
    cur_needs_a = cur_alu && (cur_sub != SUB_MVN);
  end

  // Next state and IR capture; load and start only act while idle.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (load)  ir_d    = instr;
        if (start) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (cur_mov_imm)                  state_d = S_WRITE_IMM;
        else if (cur_needs_a)             state_d = S_GET_A;
        else if (cur_mov_reg || cur_alu)  state_d = S_GET_B;
        else                              state_d = S_WAIT;
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_OPERATE;
      S_OPERATE: begin
        if (cur_alu && (cur_sub == SUB_CMP)) state_d = S_WAIT;
        else                                 state_d = S_WRITE_REG;
      end
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  // Field extraction from the IR value that will be live next cycle.
  always_comb begin
    nxt_op      = ir_d[15:13];
    nxt_sub     = ir_d[12:11];
    nxt_rn      = ir_d[10:8];
    nxt_rd      = ir_d[7:5];
    nxt_sh      = ir_d[4:3];
    nxt_rm      = ir_d[2:0];
    nxt_mov_reg = (nxt_op == OP_MOV) && (nxt_sub == SUB_MOV_REG);
    nxt_cmp     = (nxt_op == OP_ALU) && (nxt_sub == SUB_CMP);
  end

  // Output decode for the state being entered; everything defaults to 0.
  always_comb begin
    waiting_d   = (state_d == S_WAIT);
    w_addr_d    = 3'd0;
    r_addr_d    = 3'd0;
    w_en_d      = 1'b0;
    wb_sel_d    = 2'b00;
    en_a_d      = 1'b0;
    en_b_d      = 1'b0;
    en_c_d      = 1'b0;
    en_status_d = 1'b0;
    sel_a_d     = 1'b0;
    shift_op_d  = 2'b00;
    alu_op_d    = 2'b00;
    case (state_d)
      S_WRITE_IMM: begin
        w_en_d   = 1'b1;
        wb_sel_d = WB_SXIMM8;
        w_addr_d = nxt_rn;
      end
      S_GET_A: begin
        r_addr_d = nxt_rn;
        en_a_d   = 1'b1;
      end
      S_GET_B: begin
        r_addr_d = nxt_rm;
        en_b_d   = 1'b1;
      end
      S_OPERATE: begin
        shift_op_d = nxt_sh;
        if (nxt_mov_reg) begin
          // MOV reg passes B through the ALU as 0 + B.
          sel_a_d  = 1'b1;
          alu_op_d = 2'b00;
        end else begin
          alu_op_d    = nxt_sub;
          en_status_d = 1'b1;
        end
        // CMP only updates status; C keeps its previous value.
        en_c_d = !nxt_cmp;
      end
      S_WRITE_REG: begin
        w_en_d   = 1'b1;
        wb_sel_d = WB_C;
        w_addr_d = nxt_rd;
      end
      default: ;
    endcase
  end

  // State, IR and registered control outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_WAIT;
      ir_q        <= 16'h0000;
      waiting_q   <= 1'b1;
      w_addr_q    <= 3'd0;
      r_addr_q    <= 3'd0;
      w_en_q      <= 1'b0;
      wb_sel_q    <= 2'b00;
      en_a_q      <= 1'b0;
      en_b_q      <= 1'b0;
      en_c_q      <= 1'b0;
      en_status_q <= 1'b0;
      sel_a_q     <= 1'b0;
      shift_op_q  <= 2'b00;
      alu_op_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      waiting_q   <= waiting_d;
      w_addr_q    <= w_addr_d;
      r_addr_q    <= r_addr_d;
      w_en_q      <= w_en_d;
      wb_sel_q    <= wb_sel_d;
      en_a_q      <= en_a_d;
      en_b_q      <= en_b_d;
      en_c_q      <= en_c_d;
      en_status_q <= en_status_d;
      sel_a_q     <= sel_a_d;
      shift_op_q  <= shift_op_d;
      alu_op_q    <= alu_op_d;
    end
  end

  assign waiting   = waiting_q;
  assign w_addr    = w_addr_q;
  assign r_addr    = r_addr_q;
  assign w_en      = w_en_q;
  assign wb_sel    = wb_sel_q;
  assign en_A      = en_a_q;
  assign en_B      = en_b_q;
  assign en_C      = en_c_q;
  assign en_status = en_status_q;
  assign sel_A     = sel_a_q;
  // The decoded instruction set never uses the immediate B operand.
  assign sel_B     = 1'b0;
  assign shift_op  = shift_op_q;
  assign ALU_op    = alu_op_q;

  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule
